imem_loader: RTL
================

# imem_loader

Boot-time program loader that writes instruction memory, the counterpart to the CPU's read-only instruction fetch path. Accepts a length-prefixed byte stream over a valid/ready handshake, packs bytes into little-endian 32-bit words and issues one word write per packed word into the instruction memory's write port. Holds the CPU in reset until the image is fully written, then releases it and flags completion.

## Interface
- ADDR_WIDTH, 16, byte-address width of instruction memory write port
- INSTR_WIDTH, 32, instruction word width; fixed at 32 (4 bytes/word)
- MAX_WORDS, 1024, instruction memory capacity in words
- clk  in  1  system clock, rising edge
- rst  in  1  reset; synchronous, active-low
- in_valid  in  1  byte on in_data valid
- in_data  in  8  stream byte
- in_ready  out  1  loader can accept a byte
- mem_we  out  1  instruction memory write enable, one-cycle pulse per word
- mem_addr  out  ADDR_WIDTH  byte address of write, word-aligned
- mem_data  out  INSTR_WIDTH  word to write
- cpu_rst  out  1  active-high reset to CPU core; high until load complete
- done  out  1  load complete, sticky until rst
- err  out  1  header word count exceeded MAX_WORDS, sticky until rst

## Operation
- Frame: 2 header bytes = word count N (16-bit, low byte first), then 4N payload bytes, each word little-endian (first byte -> bits 7:0).
- Byte transfer occurs on a rising edge with in_valid && in_ready; in_data is ignored otherwise; in_valid may drop at any time without effect.
- States: HDR_LO -> HDR_HI -> DATA -> DRAIN -> DONE.
  - HDR_LO: capture N[7:0]. HDR_HI: capture N[15:8]; if N==0 go to DRAIN, else to DATA.
  - DATA: byte counter 0..3 fills word; on 4th byte, write issued, word counter increments; after word N-1 go to DRAIN.
  - DRAIN: one cycle, no acceptance; next DONE.
  - DONE: terminal until rst.
- in_ready = 1 in HDR_LO, HDR_HI, DATA; 0 in DRAIN, DONE and while rst low.
- mem_addr = word_index * 4, starting at 0; word counter is ADDR_WIDTH-2 bits wide.
- N > MAX_WORDS: err set on HDR_HI edge; all 4N bytes still consumed; words with index >= MAX_WORDS produce no mem_we; addresses never wrap.
- cpu_rst = 1 in every state except DONE; done = (state == DONE).
- rst low mid-load: return to HDR_LO, clear counters, err, done; partially written memory is not cleared; mem_we deasserts immediately (next edge).

## Timing
- Reset values: in_ready 0, mem_we 0, mem_addr 0, mem_data 0, cpu_rst 1, done 0, err 0; state HDR_LO.
- Throughput: one byte per cycle; one word every 4 accepted bytes.
- mem_we/mem_addr/mem_data are registered, set on the edge accepting a word's 4th byte, valid for exactly the following cycle; mem_data/mem_addr hold last value after.
- Last mem_we cycle coincides with DRAIN; done rises and cpu_rst falls on the edge after, so the CPU leaves reset with memory complete.
- N==0: HDR_HI edge -> DRAIN -> DONE; done high 2 cycles after the second header byte is accepted.

## Structure
- Package imem_loader_pkg: state enum (HDR_LO, HDR_HI, DATA, DRAIN, DONE), BYTES_PER_WORD = 4, HDR_BYTES = 2, WORD_OFFSET = 4.
- Sub-module byte_packer: 2-bit byte index plus 32-bit shift/insert register; inputs byte strobe and clear, outputs word and word_complete pulse. FSM, counters and write-port registers stay in imem_loader.

## Test plan
- Header 0x02,0x00 then bytes 13 05 A0 00 93 05 F0 0F, in_valid held high -> mem_we pulses: addr 0x0000 data 0x00A00513, addr 0x0004 data 0x0FF00593; done high, cpu_rst low 1 cycle after second pulse.
- Same stream with in_valid toggled every other cycle -> identical writes and data; no byte dropped or duplicated.
- Header 0x00,0x00 -> no mem_we; done high 2 cycles after header; in_ready low thereafter.
- MAX_WORDS=2, header 0x03,0x00 plus 12 bytes -> err high after header; writes at 0x0000, 0x0004 only; all 12 bytes accepted; done asserts.
- rst low for 1 cycle after 6 payload bytes of a 2-word load -> outputs at reset values; restart with fresh frame writes from addr 0x0000.
- Bytes presented after done -> in_ready 0, no mem_we, outputs unchanged.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
// The frame is a 16-bit little-endian word count followed by little-endian 32-bit words.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    HDR_LO = 3'd0,
    HDR_HI = 3'd1,
    DATA   = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } loaderState_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int HDR_BYTES      = 2;
  localparam int WORD_OFFSET    = 4;

  // Places byte b into byte lane idx of word, leaving the other lanes untouched.
  function automatic logic [31:0] insertByte(input logic [31:0] word,
                                             input logic [1:0]  idx,
                                             input logic [7:0]  b);
    logic [31:0] result;
    result = word;
    result[{idx, 3'b000} +: 8] = b;
    return result;
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs a byte stream into little-endian 32-bit words; the first byte lands in bits 7:0.
// word is combinational so the completed word is available on the edge taking its 4th byte.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        byteStb,
  input  logic        clear,
  input  logic [7:0]  byteIn,
  output logic [31:0] word,
  output logic        wordComplete
);

  logic [1:0]  byteIdx;
  logic [31:0] shiftReg;

  assign word         = insertByte(shiftReg, byteIdx, byteIn);
  assign wordComplete = byteStb && (byteIdx == 2'd3);

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      byteIdx  <= 2'd0;
      shiftReg <= 32'd0;
    end else if (byteStb) begin
      byteIdx  <= byteIdx + 2'd1;
      shiftReg <= wordComplete ? 32'd0 : word;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: consumes a length-prefixed byte stream, writes instruction memory word by word,
// and holds the CPU in reset until the whole image is written.
//
//   state  | meaning
//   HDR_LO | waiting for word count bits 7:0
//   HDR_HI | waiting for word count bits 15:8
//   DATA   | receiving payload bytes, one memory write per 4 bytes
//   DRAIN  | last write in flight, no bytes accepted
//   DONE   | image complete, CPU released; terminal until rst
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int INSTR_WIDTH = 32,
  parameter int MAX_WORDS   = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  output logic                   in_ready,
  output logic                   mem_we,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [INSTR_WIDTH-1:0] mem_data,
  output logic                   cpu_rst,
  output logic                   done,
  output logic                   err
);

  localparam int IDX_W = ADDR_WIDTH - 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_WORDS - 1);

  loaderState_t     state;
  logic [7:0]       hdrLo;
  logic [15:0]      hdrCount;
  logic [15:0]      wordsLeft;
  logic [IDX_W-1:0] wordIdx;
  logic             memFull;
  logic             accept;
  logic             hdrOverflow;
  logic [31:0]      packedWord;
  logic             wordComplete;

  assign in_ready = rst && ((state == HDR_LO) || (state == HDR_HI) || (state == DATA));
  assign accept   = in_valid && in_ready;
  assign hdrCount = {in_data, hdrLo};
  assign hdrOverflow = 32'(hdrCount) > MAX_WORDS;

  assign done    = (state == DONE);
  assign cpu_rst = (state != DONE);

  byte_packer uPacker (
    .clk          (clk),
    .rst          (rst),
    .byteStb      (accept && (state == DATA)),
    .clear        (accept && (state == HDR_HI)),
    .byteIn       (in_data),
    .word         (packedWord),
    .wordComplete (wordComplete)
  );

  // wordsLeft counts down to terminal count 1; wordIdx stops at the last in-range word so
  // oversized images are drained without wrapping the write address.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= HDR_LO;
      hdrLo     <= 8'd0;
      wordsLeft <= 16'd0;
      wordIdx   <= '0;
      memFull   <= 1'b0;
      err       <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        HDR_LO: begin
          if (accept) begin
            hdrLo <= in_data;
            state <= HDR_HI;
          end
        end
        HDR_HI: begin
          if (accept) begin
            wordsLeft <= hdrCount;
            err       <= hdrOverflow;
            state     <= (hdrCount == 16'd0) ? DRAIN : DATA;
          end
        end
        DATA: begin
          if (wordComplete) begin
            wordsLeft <= wordsLeft - 16'd1;
            if (wordsLeft == 16'd1) state <= DRAIN;
            if (!memFull) begin
              mem_we   <= 1'b1;
              mem_addr <= {wordIdx, 2'b00};
              mem_data <= packedWord;
              if (wordIdx == LAST_IDX) memFull <= 1'b1;
              else wordIdx <= wordIdx + 1'b1;
            end
          end
        end
        DRAIN:   state <= DONE;
        DONE:    state <= DONE;
        default: state <= HDR_LO;
      endcase
    end
  end

endmodule
